multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 7, width of the opcode input.
REQ-002 SHALL have parameter FUNCT3_W, default 3, width of the funct3 input.
REQ-003 SHALL have one clock and a synchronous, active-high reset; port names clk and reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  OPCODE_W  instr[6:0] from the datapath.
REQ-007 funct3  input  FUNCT3_W  instr[14:12] from the datapath.
REQ-008 im_req / im_ready  output / input  1 each  instruction-fetch handshake.
REQ-009 dm_req / dm_ready  output / input  1 each  data-memory handshake.
REQ-010 ir_write, pc_write  output  1 each  instruction-register load; PC update strobe.
REQ-011 jump, beq, bne, alu_src, reg_dst, mem_to_reg, rf_write_en, dm_write_en  output  1 each  datapath controls.
REQ-012 alu_op  output  2  ALU class: 00 add, 01 branch compare, 10 R-type, 11 I-ALU.
REQ-013 trap  output  1  illegal-opcode indication; sticky until reset.

Function
REQ-014 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
REQ-015 Legal opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000 = beq, 001 = bne), JAL 1101111.
REQ-016 FETCH: im_req=1. When im_ready=1 in the same cycle: ir_write=1 and advance to DECODE. Otherwise stay in FETCH.
REQ-017 DECODE: latch opcode and funct3 into internal registers. Illegal opcode, or BRANCH with funct3 not 000/001: go to TRAP. Otherwise go to EXECUTE.
REQ-018 From EXECUTE through the end of the instruction, alu_src and alu_op SHALL be driven from the latched opcode and held constant.
- alu_src=1 for I-ALU, LOAD, STORE.
- alu_op per REQ-012: LOAD/STORE 00, BRANCH 01, R 10, I-ALU 11.
REQ-019 EXECUTE by class:
- BRANCH: pc_write=1, plus beq or bne per funct3; go to FETCH.
- JAL: pc_write=1, jump=1, rf_write_en=1; go to FETCH.
- LOAD/STORE: go to MEM.
- R/I-ALU: go to WRITEBACK.
REQ-020 MEM: dm_req=1; dm_write_en=1 for STORE only. Hold until dm_ready=1.
- STORE on dm_ready: pc_write=1, go to FETCH.
- LOAD on dm_ready: go to WRITEBACK.
REQ-021 WRITEBACK: rf_write_en=1, pc_write=1; mem_to_reg=1 for LOAD; reg_dst=1 for R-type; go to FETCH.
REQ-022 pc_write SHALL pulse exactly once per retired instruction, in its final state.
REQ-023 With zero-wait memory, cycles per instruction SHALL be: BRANCH/JAL 3, R/I-ALU 4, STORE 4, LOAD 5. Each wait cycle adds exactly one.
REQ-024 im_ready outside FETCH and dm_ready outside MEM SHALL be ignored.
REQ-025 A request SHALL remain asserted and its outputs stable until the corresponding ready is sampled high.
REQ-026 TRAP: trap=1; all other outputs 0; no exit except reset.
REQ-027 All outputs SHALL be Moore/registered-state decoded; none SHALL depend combinationally on opcode or funct3 after DECODE.

Reset
REQ-028 While reset=1, all outputs SHALL be 0; state SHALL become FETCH and the latched opcode/funct3 SHALL become 0 on the clock edge.
REQ-029 Reset asserted in any state, including mid-wait in FETCH or MEM, SHALL drop im_req/dm_req in that cycle and resume FETCH on the first cycle after deassertion; trap SHALL clear.

Structure
REQ-030 A shared package SHALL hold: the state enum, opcode constants, the alu_op encodings, and the funct3 values for beq/bne.
REQ-031 A combinational sub-module opcode_decode SHALL map the latched opcode/funct3 to class, legality, alu_src and alu_op; the FSM SHALL instantiate it once.

Verification
REQ-032 R-type 0110011, im_ready and dm_ready tied 1 -> ir_write at cycle 1; rf_write_en=1, reg_dst=1, pc_write=1 at cycle 4; im_req again at cycle 5.
REQ-033 LOAD with dm_ready delayed 3 cycles -> dm_req held 4 cycles with dm_write_en=0; then WRITEBACK with mem_to_reg=1; 8 cycles total.
REQ-034 BRANCH funct3=001 -> bne=1, beq=0, pc_write=1 in cycle 3; funct3=010 -> trap=1 from cycle 3, stays 1 for 20 cycles.
REQ-035 Reset pulsed while in MEM waiting on a STORE -> dm_req and dm_write_en go 0 in the reset cycle; no pc_write; FETCH with im_req=1 on the first cycle after release.
REQ-036 Spurious dm_ready held 1 during FETCH/DECODE of a JAL -> no state skip; JAL retires in 3 cycles with jump=1, rf_write_en=1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared types and constants for the multicycle control FSM
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_IALU   = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// rtl/multicycle_control_opcode_decode.sv - opcode/funct3 to instruction class and ALU controls
module opcode_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int FUNCT3_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  output op_class_t           op_class,
  output logic                legal,
  output logic                alu_src,
  output logic [1:0]          alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPCODE_W'(OP_R):     op_class = CLS_R;
      OPCODE_W'(OP_I):     op_class = CLS_I;
      OPCODE_W'(OP_LOAD):  op_class = CLS_LOAD;
      OPCODE_W'(OP_STORE): op_class = CLS_STORE;
      OPCODE_W'(OP_JAL):   op_class = CLS_JAL;
      // Only beq/bne are implemented; other branch conditions trap.
      OPCODE_W'(OP_BRANCH): begin
        if (funct3 == FUNCT3_W'(F3_BEQ) || funct3 == FUNCT3_W'(F3_BNE)) begin
          op_class = CLS_BRANCH;
        end
      end
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    legal   = (op_class != CLS_ILLEGAL);
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    case (op_class)
      CLS_R:      alu_op = ALU_RTYPE;
      CLS_I:      begin alu_src = 1'b1; alu_op = ALU_IALU; end
      CLS_LOAD:   alu_src = 1'b1;
      CLS_STORE:  alu_src = 1'b1;
      CLS_BRANCH: alu_op = ALU_BRANCH;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with fetch/data-memory handshakes
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int FUNCT3_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  output logic                im_req,
  input  logic                im_ready,
  output logic                dm_req,
  input  logic                dm_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                jump,
  output logic                beq,
  output logic                bne,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                rf_write_en,
  output logic                dm_write_en,
  output logic [1:0]          alu_op,
  output logic                trap
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNCT3_W-1:0] f3_q;

  logic [OPCODE_W-1:0] dec_opcode;
  logic [FUNCT3_W-1:0] dec_funct3;
  op_class_t           dec_class;
  logic                dec_legal;
  logic                dec_alu_src;
  logic [1:0]          dec_alu_op;

  // In DECODE the live instruction picks the next state; afterwards only the
  // latched copy reaches the decoder, so outputs never see opcode/funct3.
  assign dec_opcode = (state_q == S_DECODE) ? opcode : op_q;
  assign dec_funct3 = (state_q == S_DECODE) ? funct3 : f3_q;

  opcode_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNCT3_W (FUNCT3_W)
  ) u_decode (
    .opcode   (dec_opcode),
    .funct3   (dec_funct3),
    .op_class (dec_class),
    .legal    (dec_legal),
    .alu_src  (dec_alu_src),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (im_ready) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (dec_class)
          CLS_BRANCH, CLS_JAL: state_d = S_FETCH;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_R, CLS_I:        state_d = S_WRITEBACK;
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (dm_ready) state_d = (dec_class == CLS_STORE) ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    im_req      = 1'b0;
    dm_req      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    jump        = 1'b0;
    beq         = 1'b0;
    bne         = 1'b0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    rf_write_en = 1'b0;
    dm_write_en = 1'b0;
    alu_op      = 2'b00;
    trap        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          im_req   = 1'b1;
          ir_write = im_ready;
        end
        S_EXECUTE: begin
          alu_src = dec_alu_src;
          alu_op  = dec_alu_op;
          if (dec_class == CLS_BRANCH) begin
            pc_write = 1'b1;
            beq      = (f3_q == FUNCT3_W'(F3_BEQ));
            bne      = (f3_q == FUNCT3_W'(F3_BNE));
          end
          if (dec_class == CLS_JAL) begin
            pc_write    = 1'b1;
            jump        = 1'b1;
            rf_write_en = 1'b1;
          end
        end
        S_MEM: begin
          alu_src     = dec_alu_src;
          alu_op      = dec_alu_op;
          dm_req      = 1'b1;
          dm_write_en = (dec_class == CLS_STORE);
          pc_write    = (dec_class == CLS_STORE) && dm_ready;
        end
        S_WRITEBACK: begin
          alu_src     = dec_alu_src;
          alu_op      = dec_alu_op;
          rf_write_en = 1'b1;
          pc_write    = 1'b1;
          mem_to_reg  = (dec_class == CLS_LOAD);
          reg_dst     = (dec_class == CLS_R);
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5, C_ILL = 6;

  localparam logic [14:0] V_IM   = 15'h4000;
  localparam logic [14:0] V_DM   = 15'h2000;
  localparam logic [14:0] V_IRW  = 15'h1000;
  localparam logic [14:0] V_PCW  = 15'h0800;
  localparam logic [14:0] V_JMP  = 15'h0400;
  localparam logic [14:0] V_BEQ  = 15'h0200;
  localparam logic [14:0] V_BNE  = 15'h0100;
  localparam logic [14:0] V_ASRC = 15'h0080;
  localparam logic [14:0] V_RDST = 15'h0040;
  localparam logic [14:0] V_M2R  = 15'h0020;
  localparam logic [14:0] V_RFW  = 15'h0010;
  localparam logic [14:0] V_DMW  = 15'h0008;
  localparam logic [14:0] V_TRAP = 15'h0001;

  typedef struct {
    logic [14:0] exp;
    bit          fetch;
    bit          mem;
    bit          hold;
    bit          rdy;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        im_ready = 1'b0, dm_ready = 1'b0;
  logic        im_req, dm_req, ir_write, pc_write, jump, beq, bne, alu_src;
  logic        reg_dst, mem_to_reg, rf_write_en, dm_write_en, trap;
  logic [1:0]  alu_op;
  logic [14:0] obs;

  int    vectors = 0;
  int    miscompares = 0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(7), .FUNCT3_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .im_req(im_req), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .ir_write(ir_write), .pc_write(pc_write), .jump(jump), .beq(beq), .bne(bne),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .rf_write_en(rf_write_en), .dm_write_en(dm_write_en), .alu_op(alu_op), .trap(trap)
  );

  assign obs = {im_req, dm_req, ir_write, pc_write, jump, beq, bne, alu_src,
                reg_dst, mem_to_reg, rf_write_en, dm_write_en, alu_op, trap};

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return (f3 <= 3'd1) ? C_BR : C_ILL;
      7'b1101111: return C_JAL;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [14:0] alu_bits(input int c);
    case (c)
      C_R:             return 15'(2'b10) << 1;
      C_I:             return V_ASRC | (15'(2'b11) << 1);
      C_LOAD, C_STORE: return V_ASRC;
      C_BR:            return 15'(2'b01) << 1;
      default:         return '0;
    endcase
  endfunction

  task automatic push(input logic [14:0] e, input bit f, input bit m, input bit h, input bit r);
    step_t s;
    s.exp = e; s.fetch = f; s.mem = m; s.hold = h; s.rdy = r;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle trace of one instruction, derived from its class.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int im_w,
                       input int dm_w, input int trap_n);
    int          c;
    logic [14:0] a;
    c = classify(op, f3);
    a = alu_bits(c);
    q.delete();
    for (int i = 0; i < im_w; i++) push(V_IM, 1, 0, 1, 0);
    push(V_IM | V_IRW, 1, 0, 1, 1);
    push('0, 0, 0, 1, 0);
    if (c == C_ILL) begin
      for (int i = 0; i < trap_n; i++) push(V_TRAP, 0, 0, 0, 0);
      return;
    end
    case (c)
      C_BR:  push(a | V_PCW | ((f3 == 3'd0) ? V_BEQ : V_BNE), 0, 0, 0, 0);
      C_JAL: push(a | V_PCW | V_JMP | V_RFW, 0, 0, 0, 0);
      C_LOAD, C_STORE: begin
        push(a, 0, 0, 0, 0);
        for (int i = 0; i < dm_w; i++) push(a | V_DM | ((c == C_STORE) ? V_DMW : '0), 0, 1, 0, 0);
        if (c == C_STORE) push(a | V_DM | V_DMW | V_PCW, 0, 1, 0, 1);
        else begin
          push(a | V_DM, 0, 1, 0, 1);
          push(a | V_RFW | V_PCW | V_M2R, 0, 0, 0, 0);
        end
      end
      default: begin
        push(a, 0, 0, 0, 0);
        push(a | V_RFW | V_PCW | ((c == C_R) ? V_RDST : '0), 0, 0, 0, 0);
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [14:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    im_ready = 1'($urandom);
    dm_ready = 1'($urandom);
    #1 check(tag, '0);
  endtask

  // Drives one instruction; readies outside their phase are random (or 1 if spur).
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input int im_w, input int dm_w, input int trap_n,
                           input int abort_at, input bit spur);
    build(op, f3, im_w, dm_w, trap_n);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      if (i == abort_at) begin
        reset = 1'b1;
        im_ready = 1'b1;
        dm_ready = 1'b1;
        #1 check($sformatf("%s reset_at_step%0d", name, i), '0);
        return;
      end
      opcode   = q[i].hold ? op : 7'($urandom);
      funct3   = q[i].hold ? f3 : 3'($urandom);
      im_ready = q[i].fetch ? q[i].rdy : (spur ? 1'b1 : 1'($urandom));
      dm_ready = q[i].mem   ? q[i].rdy : (spur ? 1'b1 : 1'($urandom));
      #1 check($sformatf("%s step%0d op=%b f3=%0d", name, i, op, f3), q[i].exp);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         k;

    do_reset("reset_cycle0");
    do_reset("reset_cycle1");

    run_instr("rtype_zero_wait", 7'b0110011, 3'd0, 0, 0, 0, -1, 1'b1);
    run_instr("load_dm_wait3",   7'b0000011, 3'd2, 0, 3, 0, -1, 1'b0);
    run_instr("branch_bne",      7'b1100011, 3'd1, 0, 0, 0, -1, 1'b0);
    run_instr("branch_beq",      7'b1100011, 3'd0, 2, 0, 0, -1, 1'b0);
    run_instr("jal_spurious",    7'b1101111, 3'd0, 0, 0, 0, -1, 1'b1);
    run_instr("store_reset_mem", 7'b0100011, 3'd2, 0, 3, 0, 4, 1'b0);
    run_instr("after_reset_i",   7'b0010011, 3'd0, 1, 0, 0, -1, 1'b0);
    run_instr("branch_f3_010",   7'b1100011, 3'd2, 0, 0, 20, -1, 1'b1);
    do_reset("trap_clear");
    run_instr("store_after_trap", 7'b0100011, 3'd0, 0, 2, 0, -1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 7);
      f3 = 3'($urandom);
      case (k)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: begin op = 7'b1100011; f3 = 3'($urandom_range(0, 1)); end
        5: op = 7'b1101111;
        6: op = 7'b1100011;
        default: op = 7'($urandom);
      endcase
      run_instr($sformatf("rand%0d", n), op, f3, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(1, 4), -1, 1'b0);
      if (classify(op, f3) == C_ILL) do_reset($sformatf("rand%0d_trap_reset", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
